mult_fu: RTL and testbench
==========================

MULT_FU -- requirements
Module: mult_fu

Interface
REQ-001 SHALL have parameter STAGES, default 4, meaning pipeline depth in cycles, legal values 2..8.
REQ-002 SHALL have parameter XLEN, default 32, meaning operand width.
REQ-003 SHALL have parameter PREG_W, default 6, meaning physical-register tag width.
REQ-004 SHALL have parameter BR_W, default 4, meaning branch-mask width.
REQ-005 SHALL have port clock, input, 1, the only clock.
REQ-006 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port in_valid, input, 1, the issued mult packet from the RS is valid.
REQ-008 SHALL have ports in_opa and in_opb, input, XLEN each, operands.
REQ-009 SHALL have port in_func, input, 2, with encoding 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU.
REQ-010 SHALL have port in_tag, input, PREG_W, destination physical register.
REQ-011 SHALL have port in_b_mask, input, BR_W, branch dependencies.
REQ-012 SHALL have port br_id, input, BR_W, one-hot resolving branch.
REQ-013 SHALL have port br_task, input, 2, with encoding 0 NOTHING, 1 CLEAR, 2 SQUASH.
REQ-014 SHALL have port cdb_gnt, input, 1, CDB arbiter accepts the current output.
REQ-015 SHALL have port busy, output, 1, fed to the RS fu_mult_busy; when high the FU cannot accept an op.
REQ-016 SHALL have ports out_valid (1), out_result (XLEN), out_tag (PREG_W) and out_b_mask (BR_W), all outputs, forming the CDB request.

Function
REQ-017 SHALL hold one op per stage, each with a valid bit, func, tag, b_mask and partial state.
- Partial-product split is implementation-defined.
- Final result SHALL equal the RISC-V M-extension definition for in_func.
REQ-018 SHALL, with no stall, present an op accepted at edge k on out_valid after edge k+STAGES-1, i.e. STAGES cycles of latency.
REQ-019 SHALL define a stall as out_valid and not cdb_gnt.
- On a stall, all stages hold.
- busy SHALL equal stall, computed combinationally.
REQ-020 SHALL accept an op only when in_valid and not busy.
- An op presented while busy is not captured; the RS must retry.
REQ-021 SHALL hold out_result, out_tag and out_b_mask stable while out_valid is high and cdb_gnt is low.
REQ-022 SHALL, on br_task SQUASH, clear at the next edge the valid bit of every stage whose b_mask AND br_id is nonzero.
- This applies to the incoming op, which is dropped.
- out_valid SHALL be suppressed combinationally in the squash cycle if the final stage matches.
REQ-023 SHALL, on br_task CLEAR, XOR br_id out of every matching stage b_mask and of the incoming in_b_mask at the next edge.
- out_b_mask SHALL reflect the cleared mask in the same cycle.
REQ-024 SHALL treat a squash that frees the final stage as ending any stall in that cycle, so busy drops.
REQ-025 SHALL ignore br_task value 3.
REQ-026 SHALL let a bubble advance normally, so an empty stage never blocks an upstream stage when not stalled.

Reset
REQ-027 SHALL, while reset is low, asynchronously clear all stage valid bits and drive out_valid=0, busy=0, out_result=0, out_tag=0, out_b_mask=0.
REQ-028 SHALL discard in-flight ops on reset mid-operation.
- The first acceptance SHALL be on the first rising edge after reset deasserts.

Configuration
REQ-029 SHALL, with MULT_FU_PERF_CNT_EN defined, add 32-bit outputs perf_done and perf_stall.
- perf_done counts ops granted by the CDB.
- perf_stall counts stall cycles.
- Both are cleared by reset and wrap modulo 2^32.
REQ-030 SHALL, without MULT_FU_PERF_CNT_EN, have neither port nor counter logic.

Verification
REQ-031 SHALL cover this scenario: MUL opa=7, opb=6, tag=5, cdb_gnt held 1 -> out_valid high exactly 4 cycles after accept with result=42, tag=5.
REQ-032 SHALL cover this scenario: MULHU opa=0xFFFFFFFF, opb=0xFFFFFFFF -> 0xFFFFFFFE; MULH opa=0x80000000, opb=0x80000000 -> 0x40000000; MULHSU opa=0xFFFFFFFF, opb=2 -> 0xFFFFFFFF.
REQ-033 SHALL cover this scenario: 4 back-to-back ops with cdb_gnt=0 for 3 cycles once the first completes -> busy=1 for those 3 cycles, no op lost or duplicated, results in issue order.
REQ-034 SHALL cover this scenario: ops with b_mask 0001 and 0010 in flight, SQUASH br_id=0001 -> only the 0010 op completes; the squashed tag never appears on out_tag.
REQ-035 SHALL cover this scenario: op b_mask 0011 in flight, CLEAR br_id=0010 -> completes with out_b_mask=0001.
REQ-036 SHALL cover this scenario: reset pulled low with 3 ops in flight, then released -> out_valid=0 immediately, and the next op issued completes normally with latency 4.

Source files
------------

// File: rtl/mult_fu.sv
// mult_fu: STAGES-deep RISC-V M-extension multiplier FU with branch-mask squash/clear and a CDB grant handshake.
// Define MULT_FU_PERF_CNT_EN to add the perf_done / perf_stall counters.
module mult_fu #(
    parameter int unsigned STAGES = 4,
    parameter int unsigned XLEN   = 32,
    parameter int unsigned PREG_W = 6,
    parameter int unsigned BR_W   = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [XLEN-1:0]   in_opa,
    input  logic [XLEN-1:0]   in_opb,
    input  logic [1:0]        in_func,
    input  logic [PREG_W-1:0] in_tag,
    input  logic [BR_W-1:0]   in_b_mask,
    input  logic [BR_W-1:0]   br_id,
    input  logic [1:0]        br_task,
    input  logic              cdb_gnt,
    output logic              busy,
    output logic              out_valid,
    output logic [XLEN-1:0]   out_result,
    output logic [PREG_W-1:0] out_tag,
    output logic [BR_W-1:0]   out_b_mask
`ifdef MULT_FU_PERF_CNT_EN
    ,
    output logic [31:0]       perf_done,
    output logic [31:0]       perf_stall
`endif
);

    typedef enum logic [1:0] {
        FN_MUL    = 2'd0,
        FN_MULH   = 2'd1,
        FN_MULHSU = 2'd2,
        FN_MULHU  = 2'd3
    } func_e;

    typedef enum logic [1:0] {
        BR_NOTHING = 2'd0,
        BR_CLEAR   = 2'd1,
        BR_SQUASH  = 2'd2,
        BR_RSVD    = 2'd3
    } br_task_e;

    localparam int unsigned LAST = STAGES - 1;

    logic [STAGES-1:0] valid_q;
    func_e             func_q [STAGES];
    logic [PREG_W-1:0] tag_q  [STAGES];
    logic [BR_W-1:0]   mask_q [STAGES];
    logic [2*XLEN-1:0] prod_q [STAGES];

    br_task_e        br;
    logic            squash;
    logic            clear;
    logic            kill_last;
    logic            stall;
    logic            accept;
    logic            sign_a;
    logic            sign_b;
    logic [2*XLEN-1:0] opa_ext;
    logic [2*XLEN-1:0] opb_ext;
    logic [2*XLEN-1:0] prod_full;

    function automatic logic kill(input logic [BR_W-1:0] m, input logic [BR_W-1:0] id, input logic sq);
        return sq & (|(m & id));
    endfunction

    function automatic logic [BR_W-1:0] clr(input logic [BR_W-1:0] m, input logic [BR_W-1:0] id,
                                            input logic cl);
        return cl ? (m & ~id) : m;
    endfunction

    assign br     = br_task_e'(br_task);
    assign squash = (br == BR_SQUASH);
    assign clear  = (br == BR_CLEAR);

    // Only the low 2*XLEN product bits are kept, so extending each operand to 2*XLEN with the
    // right signedness and multiplying modulo 2^(2*XLEN) yields every M-extension variant.
    always_comb begin
        sign_a    = (func_e'(in_func) != FN_MULHU) & in_opa[XLEN-1];
        sign_b    = ((func_e'(in_func) == FN_MUL) | (func_e'(in_func) == FN_MULH)) & in_opb[XLEN-1];
        opa_ext   = {{XLEN{sign_a}}, in_opa};
        opb_ext   = {{XLEN{sign_b}}, in_opb};
        prod_full = opa_ext * opb_ext;
    end

    assign kill_last  = kill(mask_q[LAST], br_id, squash);
    assign out_valid  = valid_q[LAST] & ~kill_last;
    assign stall      = out_valid & ~cdb_gnt;
    assign busy       = stall;
    assign accept     = in_valid & ~stall;
    assign out_tag    = tag_q[LAST];
    assign out_b_mask = clr(mask_q[LAST], br_id, clear);
    assign out_result = (func_q[LAST] == FN_MUL) ? prod_q[LAST][XLEN-1:0] : prod_q[LAST][2*XLEN-1:XLEN];

    // Branch squash/clear act on every stage even while stalled; only the shift is frozen.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < STAGES; i++) begin
                func_q[i] <= FN_MUL;
                tag_q[i]  <= '0;
                mask_q[i] <= '0;
                prod_q[i] <= '0;
            end
        end else if (stall) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                valid_q[i] <= valid_q[i] & ~kill(mask_q[i], br_id, squash);
                mask_q[i]  <= clr(mask_q[i], br_id, clear);
            end
        end else begin
            valid_q[0] <= accept & ~kill(in_b_mask, br_id, squash);
            mask_q[0]  <= clr(in_b_mask, br_id, clear);
            if (accept) begin
                func_q[0] <= func_e'(in_func);
                tag_q[0]  <= in_tag;
                prod_q[0] <= prod_full;
            end
            for (int unsigned i = 1; i < STAGES; i++) begin
                valid_q[i] <= valid_q[i-1] & ~kill(mask_q[i-1], br_id, squash);
                mask_q[i]  <= clr(mask_q[i-1], br_id, clear);
                func_q[i]  <= func_q[i-1];
                tag_q[i]   <= tag_q[i-1];
                prod_q[i]  <= prod_q[i-1];
            end
        end
    end

`ifdef MULT_FU_PERF_CNT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_done  <= '0;
            perf_stall <= '0;
        end else begin
            if (out_valid & cdb_gnt) perf_done <= perf_done + 32'd1;
            if (stall) perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mult_fu.sv
// tb_mult_fu: scoreboard bench for mult_fu; expected CDB packets come from an arithmetic reference model.
module tb_mult_fu;
    localparam int unsigned STAGES = 4;
    localparam int unsigned XLEN   = 32;
    localparam int unsigned PREG_W = 6;
    localparam int unsigned BR_W   = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic              in_valid;
    logic [XLEN-1:0]   in_opa;
    logic [XLEN-1:0]   in_opb;
    logic [1:0]        in_func;
    logic [PREG_W-1:0] in_tag;
    logic [BR_W-1:0]   in_b_mask;
    logic [BR_W-1:0]   br_id;
    logic [1:0]        br_task;
    logic              cdb_gnt;
    logic              busy;
    logic              out_valid;
    logic [XLEN-1:0]   out_result;
    logic [PREG_W-1:0] out_tag;
    logic [BR_W-1:0]   out_b_mask;
`ifdef MULT_FU_PERF_CNT_EN
    logic [31:0]       perf_done;
    logic [31:0]       perf_stall;
`endif

    mult_fu #(.STAGES(STAGES), .XLEN(XLEN), .PREG_W(PREG_W), .BR_W(BR_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_opa     (in_opa),
        .in_opb     (in_opb),
        .in_func    (in_func),
        .in_tag     (in_tag),
        .in_b_mask  (in_b_mask),
        .br_id      (br_id),
        .br_task    (br_task),
        .cdb_gnt    (cdb_gnt),
        .busy       (busy),
        .out_valid  (out_valid),
        .out_result (out_result),
        .out_tag    (out_tag),
        .out_b_mask (out_b_mask)
`ifdef MULT_FU_PERF_CNT_EN
        ,
        .perf_done  (perf_done),
        .perf_stall (perf_stall)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [XLEN-1:0]   result;
        logic [PREG_W-1:0] tag;
        logic [BR_W-1:0]   mask;
        int unsigned       cyc;
        bit                exact;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int unsigned cyc = 0;
    bit          exact_flag = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // RISC-V M-extension semantics with 64-bit arithmetic.
    function automatic logic [XLEN-1:0] ref_mul(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ub;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        ub = longint'({32'h0, b});
        case (f)
            2'd0:    begin p = {32'h0, a} * {32'h0, b}; return p[31:0];  end
            2'd1:    begin p = sa * sb;                 return p[63:32]; end
            2'd2:    begin p = sa * ub;                 return p[63:32]; end
            default: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
        endcase
    endfunction

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Model of one clock edge, using the inputs currently applied.
    task automatic model_update();
        exp_t e;
        if (!reset) begin
            exp_q.delete();
        end else begin
            if (br_task == 2'd2) begin
                for (int i = exp_q.size() - 1; i >= 0; i--)
                    if ((exp_q[i].mask & br_id) != '0) exp_q.delete(i);
            end else if (br_task == 2'd1) begin
                foreach (exp_q[i])
                    if ((exp_q[i].mask & br_id) != '0) exp_q[i].mask = exp_q[i].mask ^ br_id;
            end
            if (in_valid && !busy && !(br_task == 2'd2 && (in_b_mask & br_id) != '0)) begin
                e.result = ref_mul(in_func, in_opa, in_opb);
                e.tag    = in_tag;
                e.mask   = (br_task == 2'd1 && (in_b_mask & br_id) != '0) ? (in_b_mask ^ br_id) : in_b_mask;
                e.cyc    = cyc;
                e.exact  = exact_flag;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic step();
        @(negedge clock);
        #1;
        model_update();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                            input logic [PREG_W-1:0] t, input logic [BR_W-1:0] m);
        in_valid  = 1'b1;
        in_func   = f;
        in_opa    = a;
        in_opb    = b;
        in_tag    = t;
        in_b_mask = m;
    endtask

    task automatic drain(input string name);
        in_valid = 1'b0;
        br_task  = 2'd0;
        cdb_gnt  = 1'b1;
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) step();
        step();
        check(name, exp_q.size(), 0);
    endtask

    initial begin : monitor
        exp_t        e;
        bit          prev_stall;
        logic [31:0] prev_result;
        logic [5:0]  prev_tag;
        prev_stall = 1'b0;
        forever begin
            @(negedge clock);
            #2;
            if (reset) begin
                check("busy_eq_stall", busy, out_valid && !cdb_gnt);
                if (prev_stall && out_valid) begin
                    check("hold_result", out_result, prev_result);
                    check("hold_tag", out_tag, prev_tag);
                end
                if (out_valid && cdb_gnt) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL spurious_output: got tag 0x%0h result 0x%0h expected no output", out_tag, out_result);
                    end else begin
                        e = exp_q.pop_front();
                        check("result", out_result, e.result);
                        check("tag", out_tag, e.tag);
                        check("b_mask", out_b_mask, e.mask);
                        if (e.exact) check("latency", cyc - e.cyc, STAGES);
                        else         check("latency_min", (cyc - e.cyc) >= STAGES, 1);
                    end
                end
                prev_stall  = out_valid && !cdb_gnt;
                prev_result = out_result;
                prev_tag    = out_tag;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : driver
        int r;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_opa    = '0;
        in_opb    = '0;
        in_func   = '0;
        in_tag    = '0;
        in_b_mask = '0;
        br_id     = '0;
        br_task   = '0;
        cdb_gnt   = 1'b0;
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_result", out_result, 0);
        check("rst_out_tag", out_tag, 0);
        check("rst_out_b_mask", out_b_mask, 0);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;

        // Single MUL with exact latency.
        cdb_gnt    = 1'b1;
        exact_flag = 1'b1;
        drive_op(2'd0, 32'd7, 32'd6, 6'd5, 4'b0000);
        step();
        exact_flag = 1'b0;
        drain("drain_mul_basic");

        // High-half corner cases.
        drive_op(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd1, 4'b0000); step();
        drive_op(2'd1, 32'h8000_0000, 32'h8000_0000, 6'd2, 4'b0000); step();
        drive_op(2'd2, 32'hFFFF_FFFF, 32'd2,         6'd3, 4'b0000); step();
        drain("drain_high_half");

        // Four back-to-back ops, then three cycles of refused grant.
        cdb_gnt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_op(2'($urandom_range(0, 3)), rand_op(), rand_op(), 6'(8 + i), 4'b0000);
            step();
        end
        in_valid = 1'b0;
        cdb_gnt  = 1'b0;
        repeat (3) begin
            #1;
            check("busy_in_stall", busy, 1);
            step();
        end
        drain("drain_stall");

        // Squash the head while it is stalled at the output.
        cdb_gnt = 1'b0;
        drive_op(2'd0, 32'd11, 32'd3, 6'd10, 4'b0001); step();
        drive_op(2'd0, 32'd12, 32'd3, 6'd11, 4'b0010); step();
        in_valid = 1'b0;
        for (int i = 0; i < 20 && !out_valid; i++) step();
        check("squash_head_ready", out_valid, 1);
        br_task = 2'd2;
        br_id   = 4'b0001;
        #1;
        check("squash_suppress_valid", out_valid, 0);
        check("squash_frees_busy", busy, 0);
        step();
        br_task = 2'd0;
        br_id   = '0;
        drain("drain_squash");

        // Clear one branch bit of an in-flight op.
        cdb_gnt = 1'b1;
        drive_op(2'd0, 32'd100, 32'd5, 6'd20, 4'b0011); step();
        in_valid = 1'b0;
        br_task  = 2'd1;
        br_id    = 4'b0010;
        step();
        br_task = 2'd0;
        br_id   = '0;
        drain("drain_clear");

        // Reset with three ops in flight, then a fresh op.
        cdb_gnt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_op(2'd0, rand_op(), rand_op(), 6'(30 + i), 4'b0000);
            step();
        end
        in_valid = 1'b0;
        reset    = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_out_result", out_result, 0);
        check("midrst_out_tag", out_tag, 0);
        check("midrst_out_b_mask", out_b_mask, 0);
        step();
        step();
        reset      = 1'b1;
        exact_flag = 1'b1;
        drive_op(2'd0, 32'd123, 32'd456, 6'd33, 4'b0000);
        step();
        exact_flag = 1'b0;
        drain("drain_after_reset");

        // Randomized traffic with grants, squashes, clears and the ignored encoding.
        for (int n = 0; n < 500; n++) begin
            in_valid  = ($urandom_range(0, 99) < 60);
            in_func   = 2'($urandom_range(0, 3));
            in_opa    = rand_op();
            in_opb    = rand_op();
            in_tag    = 6'($urandom);
            in_b_mask = 4'($urandom);
            cdb_gnt   = ($urandom_range(0, 99) < 70);
            r         = $urandom_range(0, 99);
            br_task   = (r < 8) ? 2'd2 : (r < 16) ? 2'd1 : (r < 22) ? 2'd3 : 2'd0;
            br_id     = 4'(1 << $urandom_range(0, 3));
            step();
        end
        drain("drain_random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
